// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle MIPS controller and its datapath.
// The master side is the controller: it samples the instruction fields and drives every mux and enable.
// The slave side is the datapath: it supplies Op, Funct and Zero.
interface multicycle_control_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       Op;
    logic [5:0]       Funct;
    logic             Zero;
    logic             PCEn;
    logic             IorD;
    logic             MemRead;
    logic             MemWrite;
    logic             IRWrite;
    logic             RegDst;
    logic             MemtoReg;
    logic             RegWrite;
    logic             ALUSrcA;
    logic [1:0]       ALUSrcB;
    logic [1:0]       PCSource;
    logic [3:0]       ALUInSel;
    logic             IllegalOp;
    logic [CNT_W-1:0] InstrCount;
    logic [3:0]       State;

    modport master (
        input  Op, Funct, Zero,
        output PCEn, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
               ALUSrcA, ALUSrcB, PCSource, ALUInSel, IllegalOp, InstrCount, State
    );

    modport slave (
        output Op, Funct, Zero,
        input  PCEn, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
               ALUSrcA, ALUSrcB, PCSource, ALUInSel, IllegalOp, InstrCount, State
    );
endinterface

// File: rtl/multicycle_control.sv
// Moore control FSM for the multicycle MIPS datapath: fetch/decode/execute/memory/writeback.
// Latency: lw 5, sw/R/addi 4, beq/j 3, illegal opcode 2 cycles; outputs are combinational from state.
// No backpressure: one instruction in flight, every state advances each cycle; reset aborts at once.
module multicycle_control #(
    parameter int CNT_W = 32
) (
    input  logic                 CLK,
    input  logic                 RSTn,
    multicycle_control_if.master bus
);

    typedef enum logic [3:0] {
        RST_IDLE = 4'd0,
        FETCH    = 4'd1,
        DECODE   = 4'd2,
        MEMADR   = 4'd3,
        MEMRD    = 4'd4,
        MEMWB    = 4'd5,
        MEMWR    = 4'd6,
        EXEC_R   = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        ADDI_EX  = 4'd10,
        ADDI_WB  = 4'd11,
        JUMP     = 4'd12
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    // Set when the R-type in EXEC_R had an unknown funct; blocks the ALUWB register write.
    logic             wb_sup_q, wb_sup_d;

    logic [3:0]       r_alu;
    logic             funct_ok;

    // Funct field to ALU operation; unknown functs fall back to add and are flagged.
    always_comb begin
        r_alu    = ALU_ADD;
        funct_ok = 1'b1;
        case (bus.Funct)
            6'b100000: r_alu = ALU_ADD;
            6'b100010: r_alu = ALU_SUB;
            6'b000000: r_alu = 4'b0000;
            6'b000100: r_alu = 4'b0001;
            6'b000111: r_alu = 4'b0111;
            default:   funct_ok = 1'b0;
        endcase
    end

    // Next state, per-state control outputs, retire counter and write-suppress flag.
    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        wb_sup_d      = wb_sup_q;
        bus.PCEn      = 1'b0;
        bus.IorD      = 1'b0;
        bus.MemRead   = 1'b0;
        bus.MemWrite  = 1'b0;
        bus.IRWrite   = 1'b0;
        bus.RegDst    = 1'b0;
        bus.MemtoReg  = 1'b0;
        bus.RegWrite  = 1'b0;
        bus.ALUSrcA   = 1'b0;
        bus.ALUSrcB   = 2'b00;
        bus.PCSource  = 2'b00;
        bus.ALUInSel  = ALU_ADD;
        bus.IllegalOp = 1'b0;

        case (state_q)
            RST_IDLE: state_d = FETCH;
            FETCH: begin
                bus.MemRead = 1'b1;
                bus.IRWrite = 1'b1;
                bus.ALUSrcB = 2'b01;
                bus.PCEn    = 1'b1;
                wb_sup_d    = 1'b0;
                state_d     = DECODE;
            end
            DECODE: begin
                // Speculatively compute the branch target into ALUOutSR.
                bus.ALUSrcB = 2'b11;
                case (bus.Op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_R:         state_d = EXEC_R;
                    OP_BEQ:       state_d = BRANCH;
                    OP_ADDI:      state_d = ADDI_EX;
                    OP_J:         state_d = JUMP;
                    default: begin
                        bus.IllegalOp = 1'b1;
                        state_d       = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
                state_d     = (bus.Op == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                bus.MemRead = 1'b1;
                bus.IorD    = 1'b1;
                state_d     = MEMWB;
            end
            MEMWB: begin
                bus.RegWrite = 1'b1;
                bus.MemtoReg = 1'b1;
                state_d      = FETCH;
            end
            MEMWR: begin
                bus.MemWrite = 1'b1;
                bus.IorD     = 1'b1;
                state_d      = FETCH;
            end
            EXEC_R: begin
                bus.ALUSrcA   = 1'b1;
                bus.ALUInSel  = r_alu;
                bus.IllegalOp = ~funct_ok;
                wb_sup_d      = ~funct_ok;
                state_d       = ALUWB;
            end
            ALUWB: begin
                bus.RegDst   = 1'b1;
                bus.RegWrite = ~wb_sup_q;
                state_d      = FETCH;
            end
            BRANCH: begin
                bus.ALUSrcA  = 1'b1;
                bus.ALUInSel = ALU_SUB;
                bus.PCSource = 2'b01;
                bus.PCEn     = bus.Zero;
                state_d      = FETCH;
            end
            ADDI_EX: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
                state_d     = ADDI_WB;
            end
            ADDI_WB: begin
                bus.RegWrite = 1'b1;
                state_d      = FETCH;
            end
            JUMP: begin
                bus.PCSource = 2'b10;
                bus.PCEn     = 1'b1;
                state_d      = FETCH;
            end
            default: state_d = RST_IDLE;
        endcase

        // An instruction retires whenever control returns to FETCH, except the very first entry.
        if (state_d == FETCH && state_q != RST_IDLE) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // State, counter and suppress flag registers; reset drops straight to idle.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q  <= RST_IDLE;
            count_q  <= '0;
            wb_sup_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            wb_sup_q <= wb_sup_d;
        end
    end

    assign bus.InstrCount = count_q;
    assign bus.State      = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: instruction table with a per-cycle expected control-word queue.
module tb_multicycle_control;

    logic CLK = 1'b0;
    logic RSTn = 1'b0;
    always #5 CLK = ~CLK;

    multicycle_control_if #(.CNT_W(32)) bus ();

    multicycle_control #(.CNT_W(32)) dut (
        .CLK  (CLK),
        .RSTn (RSTn),
        .bus  (bus)
    );

    // {PCEn,IorD,MemRead,MemWrite,IRWrite,RegDst,MemtoReg,RegWrite,ALUSrcA,ALUSrcB,PCSource,ALUInSel,IllegalOp}
    wire [17:0] act = {bus.PCEn, bus.IorD, bus.MemRead, bus.MemWrite, bus.IRWrite, bus.RegDst,
                       bus.MemtoReg, bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB, bus.PCSource,
                       bus.ALUInSel, bus.IllegalOp};

    typedef struct {
        string      name;
        logic [5:0] op;
        logic [5:0] funct;
        logic       zero;
        int         cycles;
        logic [3:0] alu;
        logic       ill;
    } vec_t;

    int          checks = 0;
    int          failures = 0;
    int          exp_count = 0;
    logic [17:0] exp_q[$];
    vec_t        vecs[13];

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, a, e);
        end
    endtask

    function automatic logic [17:0] mk(input logic pcen, input logic iord, input logic mr,
                                       input logic mw, input logic irw, input logic rd,
                                       input logic m2r, input logic rw, input logic sa,
                                       input logic [1:0] sb, input logic [1:0] ps,
                                       input logic [3:0] alu, input logic ill);
        return {pcen, iord, mr, mw, irw, rd, m2r, rw, sa, sb, ps, alu, ill};
    endfunction

    localparam logic [17:0] W_IDLE  = {9'b0, 2'b00, 2'b00, 4'b0010, 1'b0};

    // Reference sequence of control words for one instruction, starting at FETCH.
    task automatic push_seq(input vec_t v);
        logic bad_op;
        bad_op = !(v.op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010});
        exp_q.push_back(mk(1,0,1,0,1,0,0,0,0,2'b01,2'b00,4'b0010,0));
        exp_q.push_back(mk(0,0,0,0,0,0,0,0,0,2'b11,2'b00,4'b0010,bad_op));
        case (v.op)
            6'b100011: begin
                exp_q.push_back(mk(0,0,0,0,0,0,0,0,1,2'b10,2'b00,4'b0010,0));
                exp_q.push_back(mk(0,1,1,0,0,0,0,0,0,2'b00,2'b00,4'b0010,0));
                exp_q.push_back(mk(0,0,0,0,0,0,1,1,0,2'b00,2'b00,4'b0010,0));
            end
            6'b101011: begin
                exp_q.push_back(mk(0,0,0,0,0,0,0,0,1,2'b10,2'b00,4'b0010,0));
                exp_q.push_back(mk(0,1,0,1,0,0,0,0,0,2'b00,2'b00,4'b0010,0));
            end
            6'b000000: begin
                exp_q.push_back(mk(0,0,0,0,0,0,0,0,1,2'b00,2'b00,v.alu,v.ill));
                exp_q.push_back(mk(0,0,0,0,0,1,0,!v.ill,0,2'b00,2'b00,4'b0010,0));
            end
            6'b000100:
                exp_q.push_back(mk(v.zero,0,0,0,0,0,0,0,1,2'b00,2'b01,4'b0110,0));
            6'b001000: begin
                exp_q.push_back(mk(0,0,0,0,0,0,0,0,1,2'b10,2'b00,4'b0010,0));
                exp_q.push_back(mk(0,0,0,0,0,0,0,1,0,2'b00,2'b00,4'b0010,0));
            end
            6'b000010:
                exp_q.push_back(mk(1,0,0,0,0,0,0,0,0,2'b00,2'b10,4'b0010,0));
            default: ;
        endcase
    endtask

    // Called at a negedge with the controller in FETCH; returns at the next FETCH.
    task automatic run_vec(input vec_t v);
        int n;
        bus.Op    = v.op;
        bus.Funct = v.funct;
        bus.Zero  = v.zero;
        push_seq(v);
        n = 0;
        while (1) begin
            if (exp_q.size() > 0) chk({v.name, " ctrl word"}, 32'(act), 32'(exp_q.pop_front()));
            if (bus.MemRead && bus.MemWrite) chk({v.name, " MemRead&MemWrite"}, 1, 0);
            if (bus.RegWrite && bus.MemWrite) chk({v.name, " RegWrite&MemWrite"}, 1, 0);
            @(negedge CLK);
            n++;
            if (bus.IRWrite || n >= 10) break;
        end
        chk({v.name, " cycles"}, 32'(n), 32'(v.cycles));
        if (exp_q.size() != 0) begin
            chk({v.name, " leftover expected words"}, 32'(exp_q.size()), 0);
            exp_q.delete();
        end
        exp_count++;
        chk({v.name, " InstrCount"}, bus.InstrCount, 32'(exp_count));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{"lw",      6'b100011, 6'b000000, 1'b0, 5, 4'b0010, 1'b0};
        vecs[1]  = '{"sw",      6'b101011, 6'b000000, 1'b0, 4, 4'b0010, 1'b0};
        vecs[2]  = '{"add",     6'b000000, 6'b100000, 1'b0, 4, 4'b0010, 1'b0};
        vecs[3]  = '{"sub",     6'b000000, 6'b100010, 1'b0, 4, 4'b0110, 1'b0};
        vecs[4]  = '{"sll",     6'b000000, 6'b000000, 1'b0, 4, 4'b0000, 1'b0};
        vecs[5]  = '{"sllv",    6'b000000, 6'b000100, 1'b0, 4, 4'b0001, 1'b0};
        vecs[6]  = '{"srav",    6'b000000, 6'b000111, 1'b0, 4, 4'b0111, 1'b0};
        vecs[7]  = '{"beq_z1",  6'b000100, 6'b000000, 1'b1, 3, 4'b0110, 1'b0};
        vecs[8]  = '{"beq_z0",  6'b000100, 6'b000000, 1'b0, 3, 4'b0110, 1'b0};
        vecs[9]  = '{"addi",    6'b001000, 6'b000000, 1'b0, 4, 4'b0010, 1'b0};
        vecs[10] = '{"j",       6'b000010, 6'b000000, 1'b0, 3, 4'b0010, 1'b0};
        vecs[11] = '{"bad_op",  6'b111111, 6'b000000, 1'b0, 2, 4'b0010, 1'b1};
        vecs[12] = '{"bad_fn",  6'b000000, 6'b101010, 1'b0, 4, 4'b0010, 1'b1};

        bus.Op    = 6'b0;
        bus.Funct = 6'b0;
        bus.Zero  = 1'b0;

        // Held reset: idle outputs, counter clear.
        RSTn = 1'b0;
        repeat (3) begin
            @(negedge CLK);
            chk("reset ctrl word", 32'(act), 32'(W_IDLE));
            chk("reset InstrCount", bus.InstrCount, 0);
        end
        @(posedge CLK);
        #1 RSTn = 1'b1;
        @(negedge CLK);
        chk("idle after release", 32'(act), 32'(W_IDLE));
        @(negedge CLK);
        chk("first FETCH word", 32'(act), 32'(mk(1,0,1,0,1,0,0,0,0,2'b01,2'b00,4'b0010,0)));
        chk("InstrCount after idle", bus.InstrCount, 0);

        for (int i = 0; i < 13; i++) run_vec(vecs[i]);

        // Reset dropped while a store is in MEMWR.
        bus.Op = 6'b101011;
        repeat (3) @(negedge CLK);
        chk("sw reaches MemWrite", 32'(bus.MemWrite), 1);
        #2 RSTn = 1'b0;
        #1;
        chk("MemWrite after async reset", 32'(bus.MemWrite), 0);
        chk("ctrl word after async reset", 32'(act), 32'(W_IDLE));
        chk("InstrCount after async reset", bus.InstrCount, 0);
        @(posedge CLK);
        #1 RSTn = 1'b1;
        exp_count = 0;
        @(negedge CLK);
        chk("idle after mid-reset", 32'(act), 32'(W_IDLE));
        @(negedge CLK);
        chk("FETCH after mid-reset", 32'(bus.IRWrite & bus.PCEn & bus.MemRead), 1);
        run_vec(vecs[9]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main control unit for the multicycle MIPS datapath.
- A Moore FSM that sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives every datapath mux/enable and generates the 4-bit ALUInSel code from opcode/funct.
- Keeps a retired-instruction counter and flags unsupported encodings.

Parameters:
- CNT_W, 32, width of the retired-instruction counter InstrCount.

Ports:
- CLK  input  1  system clock, all state changes on rising edge
- RSTn  input  1  asynchronous active-low reset
- Op  input  6  instruction opcode, IR[31:26]
- Funct  input  6  R-type function field, IR[5:0]
- Zero  input  1  ALU zero flag (bit 0 of ALU Zero)
- PCEn  output  1  PC register load enable
- IorD  output  1  memory address select: 0=PC, 1=ALUOutSR
- MemRead  output  1  memory read strobe
- MemWrite  output  1  memory write strobe
- IRWrite  output  1  instruction register load
- RegDst  output  1  write register select: 0=rt, 1=rd
- MemtoReg  output  1  write data select: 0=ALUOutSR, 1=MDR
- RegWrite  output  1  register file write enable
- ALUSrcA  output  1  ALUIn1 select: 0=PC, 1=A
- ALUSrcB  output  2  ALUIn2 select: 00=B, 01=const 4, 10=signext imm, 11=signext imm<<2
- PCSource  output  2  PC next select: 00=ALUOut, 01=ALUOutSR, 10=jump target
- ALUInSel  output  4  ALU operation code
- IllegalOp  output  1  one-cycle pulse on unsupported opcode or funct
- InstrCount  output  CNT_W  retired-instruction count
- State  output  4  current state encoding, for debug

Behaviour:
- RSTn low (async): state=RST_IDLE, InstrCount=0. In RST_IDLE all outputs are 0, ALUInSel=0010.
- RST_IDLE goes to FETCH unconditionally. Reset asserted mid-instruction aborts immediately; no strobe may be asserted after RSTn falls.
- Outputs are combinational from state only, with three exceptions:
  - PCEn in BRANCH = Zero.
  - ALUInSel in EXEC_R = funct decode.
  - IllegalOp (see below).
- Unlisted outputs are 0 and ALUInSel=0010 (add).
- Opcodes: R=000000, lw=100011, sw=101011, beq=000100, addi=001000, j=000010.
- Funct to ALUInSel: add 100000->0010, sub 100010->0110, sll 000000->0000, sllv 000100->0001, srav 000111->0111.
- States and outputs:
  - FETCH: MemRead, IRWrite, IorD=0, ALUSrcA=0, ALUSrcB=01, PCSource=00, PCEn=1. Next DECODE.
  - DECODE: ALUSrcA=0, ALUSrcB=11 (branch target to ALUOutSR). Next by Op: lw/sw->MEMADR, R->EXEC_R, beq->BRANCH, addi->ADDI_EX, j->JUMP; else IllegalOp=1 and next FETCH.
  - MEMADR: ALUSrcA=1, ALUSrcB=10. Next MEMRD if lw, MEMWR if sw.
  - MEMRD: MemRead, IorD=1. Next MEMWB.
  - MEMWB: RegWrite, MemtoReg=1, RegDst=0. Next FETCH.
  - MEMWR: MemWrite, IorD=1. Next FETCH.
  - EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUInSel=decode(Funct). Next ALUWB.
    - Unsupported funct: ALUInSel=0010, IllegalOp=1, and the following ALUWB suppresses RegWrite (flag latched in EXEC_R, cleared in FETCH).
  - ALUWB: RegDst=1, MemtoReg=0, RegWrite (unless suppressed). Next FETCH.
  - BRANCH: ALUSrcA=1, ALUSrcB=00, ALUInSel=0110, PCSource=01, PCEn=Zero. Next FETCH.
  - ADDI_EX: ALUSrcA=1, ALUSrcB=10. Next ADDI_WB.
  - ADDI_WB: RegDst=0, MemtoReg=0, RegWrite. Next FETCH.
  - JUMP: PCSource=10, PCEn=1. Next FETCH.
- Latency in cycles from FETCH: lw 5, sw 4, R 4, addi 4, beq 3, j 3, illegal op 2.
- InstrCount increments by 1 on every transition into FETCH from a non-RST_IDLE state, including illegal ops. It wraps from all-ones to 0.
- Writeback states use ALUOutSR, which the ALU registered on the prior edge. The controller must never assert RegWrite in the same state that computes the result.
- Invariants: MemRead and MemWrite are never both 1; RegWrite and MemWrite are never both 1.

Test Plan:
- Reset with RSTn=0 for 3 cycles, then release -> all strobes 0 during reset, InstrCount=0; RST_IDLE for one cycle, then FETCH with PCEn=1, IRWrite=1, MemRead=1.
- lw (Op=100011) -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB; IorD=1 only in MEMRD; RegWrite with MemtoReg=1 in cycle 5; InstrCount +1.
- R-type stream add, sub, sll, sllv, srav -> ALUInSel in EXEC_R = 0010, 0110, 0000, 0001, 0111; RegDst=1 RegWrite in ALUWB; InstrCount +5.
- beq with Zero=1, then Zero=0 -> PCEn=1 with PCSource=01 in BRANCH for the first; PCEn=0 for the second; both 3 cycles.
- Op=111111, then R-type with Funct=101010 -> IllegalOp pulse in DECODE and return to FETCH; second case pulses in EXEC_R with no RegWrite in ALUWB; both counted.
- RSTn dropped during MEMWR (sw) -> MemWrite deasserts asynchronously, InstrCount=0, restart through RST_IDLE.
